// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit that produces stall and forward selects from E/M/W shadow entries
//   in : clk, reset (async, active-low), d_ra1/d_ra2/d_wa (D registers),
//        d_tuse_rs0/rs1, d_tuse_rt0/rt1/rt2 (operand-use times), d_res (result class),
//        d_md, md_busy, flush
//   out: stall, fwd_rs_d/fwd_rt_d (0 RF, 1 E, 2 M, 3 W), fwd_rs_e/fwd_rt_e (0 reg, 1 M, 2 W),
//        fwd_rt_m (0 reg, 1 W)
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_ra1,
    input  logic [4:0] d_ra2,
    input  logic [4:0] d_wa,
    input  logic       d_tuse_rs0,
    input  logic       d_tuse_rs1,
    input  logic       d_tuse_rt0,
    input  logic       d_tuse_rt1,
    input  logic       d_tuse_rt2,
    input  logic [2:0] d_res,
    input  logic       d_md,
    input  logic       md_busy,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       fwd_rt_m
);
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wa;
        logic [1:0] res;
        logic [1:0] tnew;
    } ent_t;

    ent_t e, m, w, e_in;
    logic [1:0] d_cls;
    logic       rs_use, rt_use;
    logic [1:0] rs_tu, rt_tu;
    logic       unused;

    function automatic ent_t age(input ent_t x);
        age = x;
        age.tnew = x.tnew == 2'd0 ? 2'd0 : x.tnew - 2'd1;
    endfunction

    function automatic logic hit(input logic [4:0] r, input logic u, input logic [1:0] tu, input ent_t x);
        return r != 5'd0 && u && r == x.wa && x.tnew > tu;
    endfunction

    function automatic logic [1:0] sel_d(input logic [4:0] r, input ent_t xe, input ent_t xm, input ent_t xw);
        return r == 5'd0 ? 2'd0 :
               (xe.res == 2'd3 && r == xe.wa) ? 2'd1 :
               (r == xm.wa && xm.tnew == 2'd0) ? 2'd2 :
               r == xw.wa ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic [4:0] r, input ent_t xm, input ent_t xw);
        return r == 5'd0 ? 2'd0 :
               (r == xm.wa && xm.tnew == 2'd0) ? 2'd1 :
               r == xw.wa ? 2'd2 : 2'd0;
    endfunction

    // classes 4-7 collapse to no-write so they never create a hazard
    assign d_cls = d_res[2] ? 2'd0 : d_res[1:0];

    always_comb begin
        e_in.rs   = d_ra1;
        e_in.rt   = d_ra2;
        e_in.wa   = d_cls == 2'd0 ? 5'd0 : d_wa;
        e_in.res  = d_cls;
        e_in.tnew = d_cls == 2'd1 ? 2'd1 : d_cls == 2'd2 ? 2'd2 : 2'd0;
    end

    assign rs_use = d_tuse_rs0 | d_tuse_rs1;
    assign rs_tu  = d_tuse_rs0 ? 2'd0 : 2'd1;
    assign rt_use = d_tuse_rt0 | d_tuse_rt1 | d_tuse_rt2;
    assign rt_tu  = d_tuse_rt0 ? 2'd0 : d_tuse_rt1 ? 2'd1 : 2'd2;

    assign stall = hit(d_ra1, rs_use, rs_tu, e) | hit(d_ra1, rs_use, rs_tu, m) |
                   hit(d_ra2, rt_use, rt_tu, e) | hit(d_ra2, rt_use, rt_tu, m) |
                   (d_md & md_busy);

    assign fwd_rs_d = sel_d(d_ra1, e, m, w);
    assign fwd_rt_d = sel_d(d_ra2, e, m, w);
    assign fwd_rs_e = sel_e(e.rs, m, w);
    assign fwd_rt_e = sel_e(e.rt, m, w);
    assign fwd_rt_m = m.rt != 5'd0 && m.rt == w.wa;

    // W only supplies a destination; its other fields are kept for completeness
    assign unused = ^{w.rs, w.rt, w.res, w.tnew, m.rs, m.res};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e <= '0;
            m <= '0;
            w <= '0;
        end else if (flush) begin
            e <= '0;
            m <= '0;
            w <= '0;
        end else begin
            e <= stall ? '0 : e_in;
            m <= age(e);
            w <= age(m);
        end
    end
endmodule
